elevator_request_scheduler: RTL and testbench

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

---
 rtl/elevator_pkg.sv | 18 +
 rtl/elevator_floor_search.sv | 38 +++
 rtl/elevator_request_scheduler.sv | 113 +++++++++++
 tb/tb_elevator_request_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared widths, scan-state enum and floor one-hot helper for the elevator scheduler.
// The DWELL state exists only when ELEVATOR_DOOR_HOLD_EN is defined.
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

`ifdef ELEVATOR_DOOR_HOLD_EN
    typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DWELL} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_e;
`endif

    function automatic logic [MAX_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        return MAX_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_floor_search.sv
// elevator_floor_search: combinational nearest pending floor at-or-above and at-or-below a reference floor,
// plus a flag for any pending floor strictly above it.
module elevator_floor_search
    import elevator_pkg::*;
(
    input  logic [MAX_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic [FLOOR_W-1:0]    above_o,
    output logic [FLOOR_W-1:0]    below_o,
    output logic                  above_found_o,
    output logic                  below_found_o,
    output logic                  strict_above_o
);

    always_comb begin
        above_o        = '0;
        below_o        = '0;
        above_found_o  = 1'b0;
        below_found_o  = 1'b0;
        strict_above_o = 1'b0;
        // Scanning downward leaves the lowest qualifying floor as the final assignment.
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && FLOOR_W'(i) >= floor_i) begin
                above_o       = FLOOR_W'(i);
                above_found_o = 1'b1;
            end
        end
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (pending_i[i] && FLOOR_W'(i) <= floor_i) begin
                below_o       = FLOOR_W'(i);
                below_found_o = 1'b1;
            end
            if (pending_i[i] && FLOOR_W'(i) > floor_i)
                strict_above_o = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: SCAN-style call bitmap and target selection for a single car.
// Define ELEVATOR_DOOR_HOLD_EN to add a DWELL state holding the door for DWELL_CYCLES after arrival.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 16,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    output logic                  call_accept,
    input  logic [FLOOR_W-1:0]    currentFloor,
    output logic [FLOOR_W-1:0]    requestFloor,
    output logic [MAX_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  idle
);

    localparam logic [MAX_FLOORS-1:0] FLOOR_MASK = MAX_FLOORS'((17'd1 << NUM_FLOORS) - 17'd1);

    state_e                  state_q, state_d;
    logic [MAX_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]      req_q, req_d;
    logic                    dir_q, dir_d;
    logic                    arrive;
    logic [MAX_FLOORS-1:0]   set_mask, clr_mask, eff;
    logic [FLOOR_W-1:0]      above_floor, below_floor;
    logic                    above_found, below_found, any_above;

`ifdef ELEVATOR_DOOR_HOLD_EN
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign call_accept = call_valid && ({1'b0, call_floor} < 5'(NUM_FLOORS));
    assign arrive      = (currentFloor == req_q) && pending_q[currentFloor];
    assign set_mask    = call_accept ? floor_bit(call_floor) : '0;
    assign clr_mask    = arrive ? floor_bit(currentFloor) : '0;
    // Decisions use the bitmap with the served floor already removed, so an arrival steers straight on.
    assign eff         = pending_q & ~clr_mask;
    assign pending_d   = (pending_q | set_mask) & ~clr_mask & FLOOR_MASK;

    elevator_floor_search u_search (
        .pending_i      (eff),
        .floor_i        (currentFloor),
        .above_o        (above_floor),
        .below_o        (below_floor),
        .above_found_o  (above_found),
        .below_found_o  (below_found),
        .strict_above_o (any_above)
    );

    always_comb begin
        state_d = state_q;
`ifdef ELEVATOR_DOOR_HOLD_EN
        cnt_d = '0;
`endif
        case (state_q)
            ST_IDLE: state_d = (eff == '0) ? ST_IDLE : any_above ? ST_UP : ST_DOWN;
            ST_UP:   state_d = (eff == '0) ? ST_IDLE : above_found ? ST_UP : ST_DOWN;
            ST_DOWN: state_d = (eff == '0) ? ST_IDLE : below_found ? ST_DOWN : ST_UP;
`ifdef ELEVATOR_DOOR_HOLD_EN
            ST_DWELL: begin
                if (cnt_q != CNT_W'(DWELL_CYCLES - 1)) begin
                    state_d = ST_DWELL;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = (eff == '0) ? ST_IDLE :
                              dir_q ? (above_found ? ST_UP : ST_DOWN) : (below_found ? ST_DOWN : ST_UP);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef ELEVATOR_DOOR_HOLD_EN
        if (arrive && (state_q == ST_UP || state_q == ST_DOWN)) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
        end
`endif
        // The target follows the state being entered, giving a two-edge call-to-target latency.
        req_d = (state_d == ST_UP) ? above_floor : (state_d == ST_DOWN) ? below_floor : currentFloor;
        dir_d = (state_d == ST_UP) ? 1'b1 : (state_d == ST_DOWN) ? 1'b0 : dir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            req_q     <= '0;
            dir_q     <= 1'b1;
`ifdef ELEVATOR_DOOR_HOLD_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            dir_q     <= dir_d;
`ifdef ELEVATOR_DOOR_HOLD_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign requestFloor = req_q;
    assign pending      = pending_q;
    assign dir_up       = dir_q;
    assign idle         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed scenarios with hand-computed expectations for the scheduler,
// plus a NUM_FLOORS=10 instance for range filtering; ELEVATOR_DOOR_HOLD_EN adds the dwell scenario.
module tb_elevator_request_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        call_valid = 1'b0;
    logic [3:0]  call_floor = '0;
    logic [3:0]  cur = '0;
    logic        call_accept, dir_up, idle;
    logic [3:0]  request_floor;
    logic [15:0] pending;

    logic        b_valid = 1'b0;
    logic [3:0]  b_floor = '0;
    logic [3:0]  b_cur = '0;
    logic        b_accept, b_dir, b_idle;
    logic [3:0]  b_request;
    logic [15:0] b_pending;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.NUM_FLOORS(16), .DWELL_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .call_valid(call_valid), .call_floor(call_floor),
        .call_accept(call_accept), .currentFloor(cur), .requestFloor(request_floor),
        .pending(pending), .dir_up(dir_up), .idle(idle)
    );

    elevator_request_scheduler #(.NUM_FLOORS(10), .DWELL_CYCLES(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .call_valid(b_valid), .call_floor(b_floor),
        .call_accept(b_accept), .currentFloor(b_cur), .requestFloor(b_request),
        .pending(b_pending), .dir_up(b_dir), .idle(b_idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        call_valid = 1'b1; call_floor = 4'd4;
        tick(); tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_pending: got %h want 0000", pending); end
        vectors++; if (request_floor !== 4'd0) begin miscompares++; $display("FAIL reset_request: got %0d want 0", request_floor); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle); end
        vectors++; if (dir_up !== 1'b1) begin miscompares++; $display("FAIL reset_dir: got %b want 1", dir_up); end
        rst_n = 1'b1;
        tick();
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_call_ignored: got %h want 0000", pending); end
    endtask

    task automatic test_first_call();
        cur = 4'd0; call_valid = 1'b1; call_floor = 4'd10;
        #1;
        vectors++; if (call_accept !== 1'b1) begin miscompares++; $display("FAIL first_accept: got %b want 1", call_accept); end
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0400) begin miscompares++; $display("FAIL first_pending: got %h want 0400", pending); end
        vectors++; if (request_floor !== 4'd0) begin miscompares++; $display("FAIL first_req_edge1: got %0d want 0", request_floor); end
        tick();
        vectors++; if (request_floor !== 4'd10) begin miscompares++; $display("FAIL first_req_edge2: got %0d want 10", request_floor); end
        vectors++; if (dir_up !== 1'b1) begin miscompares++; $display("FAIL first_dir: got %b want 1", dir_up); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL first_busy: got %b want 0", idle); end
        cur = 4'd10;
        tick();
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL first_arrive: got %h want 0000", pending); end
        repeat (6) tick();
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL first_back_idle: got %b want 1", idle); end
        vectors++; if (request_floor !== 4'd10) begin miscompares++; $display("FAIL first_idle_req: got %0d want 10", request_floor); end
    endtask

    task automatic test_sweep();
        cur = 4'd5;
        tick();
        call_valid = 1'b1; call_floor = 4'd8;
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0100) begin miscompares++; $display("FAIL sweep_pend8: got %h want 0100", pending); end
        tick();
        vectors++; if (request_floor !== 4'd8) begin miscompares++; $display("FAIL sweep_target8: got %0d want 8", request_floor); end
        vectors++; if (dir_up !== 1'b1) begin miscompares++; $display("FAIL sweep_up: got %b want 1", dir_up); end
        call_valid = 1'b1; call_floor = 4'd2;
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0104) begin miscompares++; $display("FAIL sweep_pend28: got %h want 0104", pending); end
        vectors++; if (request_floor !== 4'd8) begin miscompares++; $display("FAIL sweep_keep8: got %0d want 8", request_floor); end
        cur = 4'd8;
        tick();
        vectors++; if (pending !== 16'h0004) begin miscompares++; $display("FAIL sweep_arrive8: got %h want 0004", pending); end
`ifdef ELEVATOR_DOOR_HOLD_EN
        repeat (4) tick();
`endif
        vectors++; if (request_floor !== 4'd2) begin miscompares++; $display("FAIL sweep_target2: got %0d want 2", request_floor); end
        vectors++; if (dir_up !== 1'b0) begin miscompares++; $display("FAIL sweep_down: got %b want 0", dir_up); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL sweep_busy: got %b want 0", idle); end
        cur = 4'd2;
        tick();
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL sweep_arrive2: got %h want 0000", pending); end
        repeat (6) tick();
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL sweep_idle: got %b want 1", idle); end
    endtask

    task automatic test_duplicate();
        call_valid = 1'b1; call_floor = 4'd7;
        tick();
        tick();
        vectors++; if (pending !== 16'h0080) begin miscompares++; $display("FAIL dup_pending: got %h want 0080", pending); end
        vectors++; if (request_floor !== 4'd7) begin miscompares++; $display("FAIL dup_target: got %0d want 7", request_floor); end
        call_valid = 1'b0;
        tick();
        vectors++; if (pending !== 16'h0080) begin miscompares++; $display("FAIL dup_hold: got %h want 0080", pending); end
        cur = 4'd7;
        tick();
        repeat (6) tick();
        vectors++; if (pending !== 16'h0000 || idle !== 1'b1) begin miscompares++; $display("FAIL dup_served: got %h/%b want 0000/1", pending, idle); end
    endtask

    task automatic test_same_cycle();
        cur = 4'd3;
        tick();
        call_valid = 1'b1; call_floor = 4'd3;
        tick();
        vectors++; if (pending !== 16'h0008) begin miscompares++; $display("FAIL same_set: got %h want 0008", pending); end
        vectors++; if (request_floor !== 4'd3) begin miscompares++; $display("FAIL same_req: got %0d want 3", request_floor); end
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL same_clear_wins: got %h want 0000", pending); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL same_idle: got %b want 1", idle); end
    endtask

    task automatic test_async_reset();
        cur = 4'd0;
        call_valid = 1'b1; call_floor = 4'd2;
        tick();
        call_floor = 4'd5;
        tick();
        call_floor = 4'd8;
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0124) begin miscompares++; $display("FAIL ares_prefill: got %h want 0124", pending); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL ares_busy: got %b want 0", idle); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL ares_pending: got %h want 0000", pending); end
        vectors++; if (request_floor !== 4'd0) begin miscompares++; $display("FAIL ares_request: got %0d want 0", request_floor); end
        vectors++; if (idle !== 1'b1 || dir_up !== 1'b1) begin miscompares++; $display("FAIL ares_idle_dir: got %b/%b want 1/1", idle, dir_up); end
        call_valid = 1'b1; call_floor = 4'd6;
        tick(); tick();
        call_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL ares_drop_calls: got %h want 0000", pending); end
        call_valid = 1'b1; call_floor = 4'd10;
        tick();
        call_valid = 1'b0;
        vectors++; if (pending !== 16'h0400) begin miscompares++; $display("FAIL ares_first_pending: got %h want 0400", pending); end
        tick();
        vectors++; if (request_floor !== 4'd10 || idle !== 1'b0) begin miscompares++; $display("FAIL ares_first_target: got %0d/%b want 10/0", request_floor, idle); end
        cur = 4'd10;
        tick();
        repeat (6) tick();
    endtask

    task automatic test_range();
        b_cur = 4'd0; b_valid = 1'b1; b_floor = 4'd12;
        #1;
        vectors++; if (b_accept !== 1'b0) begin miscompares++; $display("FAIL range_accept12: got %b want 0", b_accept); end
        tick();
        vectors++; if (b_pending !== 16'h0000) begin miscompares++; $display("FAIL range_pend12: got %h want 0000", b_pending); end
        b_floor = 4'd9;
        #1;
        vectors++; if (b_accept !== 1'b1) begin miscompares++; $display("FAIL range_accept9: got %b want 1", b_accept); end
        tick();
        vectors++; if (b_pending !== 16'h0200) begin miscompares++; $display("FAIL range_pend9: got %h want 0200", b_pending); end
        b_floor = 4'd10;
        #1;
        vectors++; if (b_accept !== 1'b0) begin miscompares++; $display("FAIL range_accept10: got %b want 0", b_accept); end
        tick();
        b_valid = 1'b0;
        vectors++; if (b_pending !== 16'h0200) begin miscompares++; $display("FAIL range_pend10: got %h want 0200", b_pending); end
    endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
    task automatic test_dwell();
        cur = 4'd3;
        tick();
        call_valid = 1'b1; call_floor = 4'd6;
        tick();
        call_valid = 1'b0;
        tick();
        call_valid = 1'b1; call_floor = 4'd9;
        tick();
        call_valid = 1'b0;
        cur = 4'd6;
        tick();
        vectors++; if (pending !== 16'h0200) begin miscompares++; $display("FAIL dwell_arrive: got %h want 0200", pending); end
        vectors++; if (request_floor !== 4'd6) begin miscompares++; $display("FAIL dwell_hold0: got %0d want 6", request_floor); end
        for (int i = 1; i < 4; i++) begin
            tick();
            vectors++; if (request_floor !== 4'd6) begin miscompares++; $display("FAIL dwell_hold%0d: got %0d want 6", i, request_floor); end
        end
        tick();
        vectors++; if (request_floor !== 4'd9 || dir_up !== 1'b1) begin miscompares++; $display("FAIL dwell_resume: got %0d/%b want 9/1", request_floor, dir_up); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_call();
        test_sweep();
        test_duplicate();
        test_same_cycle();
        test_async_reset();
        test_range();
`ifdef ELEVATOR_DOOR_HOLD_EN
        test_dwell();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
